// File: rtl/mem_arbiter_if.sv
// Bundle of requester (IF, LS) and memory-side signals for the memory arbiter.
// slave = arbiter side, master = environment side (requesters + memory).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_resp_valid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ls_req_valid;
  logic                  ls_req_ready;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic                  ls_wen;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic [3:0]            ls_wmask;
  logic                  ls_resp_valid;
  logic [DATA_WIDTH-1:0] ls_rdata;

  logic                  resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output ls_req_ready, ls_resp_valid, ls_rdata, resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_ready, ls_resp_valid, ls_rdata, resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight: IDLE (arbitrate + buffer) -> REQ -> WAIT -> IDLE,
// with a watchdog that aborts with resp_err if memory never answers.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
  localparam bit         WD_EN  = (TIMEOUT != 0);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;      // 0 = IF, 1 = LS
  logic                  prio_ls_q, prio_ls_d;  // contended tie goes to LS when set
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [7:0]            wdog_q, wdog_d;

  logic                  grant_if, grant_ls, timeout;
  logic                  if_rdy, ls_rdy, mreq, resp_v, err;
  logic [DATA_WIDTH-1:0] rdata;

  // Next-state, arbitration, buffering and watchdog.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_ls_d = prio_ls_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    wdog_d    = wdog_q;
    if_rdy    = 1'b0;
    ls_rdy    = 1'b0;
    mreq      = 1'b0;
    resp_v    = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    grant_ls  = bus.ls_req_valid && (!bus.if_req_valid || prio_ls_q);
    grant_if  = bus.if_req_valid && (!bus.ls_req_valid || !prio_ls_q);
    timeout   = WD_EN && (wdog_q == TO_CNT);

    case (state_q)
      IDLE: begin
        ls_rdy = grant_ls;
        if_rdy = grant_if;
        if (grant_ls) begin
          addr_d  = bus.ls_addr;
          wen_d   = bus.ls_wen;
          wdata_d = bus.ls_wdata;
          wmask_d = bus.ls_wmask;
          owner_d = 1'b1;
          wdog_d  = '0;
          state_d = REQ;
          // loser of a contended grant gets the next tie
          if (bus.if_req_valid) prio_ls_d = 1'b0;
        end else if (grant_if) begin
          addr_d  = bus.if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = 4'b0000;
          owner_d = 1'b0;
          wdog_d  = '0;
          state_d = REQ;
          if (bus.ls_req_valid) prio_ls_d = 1'b1;
        end
      end
      REQ: begin
        wdog_d = wdog_q + 8'd1;
        if (timeout) begin
          resp_v  = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          mreq = 1'b1;
          if (bus.mem_req_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + 8'd1;
        // a real response in the timeout cycle beats the abort
        if (bus.mem_resp_valid) begin
          resp_v  = 1'b1;
          rdata   = bus.mem_rdata;
          state_d = IDLE;
        end else if (timeout) begin
          resp_v  = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output drive; everything is forced low while reset is held.
  always_comb begin
    bus.if_req_ready  = rst & if_rdy;
    bus.ls_req_ready  = rst & ls_rdy;
    bus.mem_req_valid = rst & mreq;
    bus.if_resp_valid = rst & resp_v & !owner_q;
    bus.ls_resp_valid = rst & resp_v & owner_q;
    bus.if_rdata      = (rst && resp_v && !owner_q) ? rdata : '0;
    bus.ls_rdata      = (rst && resp_v && owner_q)  ? rdata : '0;
    bus.resp_err      = rst & resp_v & err;
    bus.mem_addr      = rst ? addr_q  : '0;
    bus.mem_wen       = rst & wen_q;
    bus.mem_wdata     = rst ? wdata_q : '0;
    bus.mem_wmask     = rst ? wmask_q : 4'b0000;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_ls_q <= 1'b1;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= 4'b0000;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_ls_q <= prio_ls_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      wdog_q    <= wdog_d;
    end
  end
endmodule
